// File: rtl/multiword_add_seq.sv
// multiword_add_seq: adds two 16*WORDS-bit operands over WORDS cycles by
// walking a single 16-bit ripple-carry adder (adder_16) across the slices,
// least significant slice first, with the slice carry held in a register.
// Optional feature macro: MULTIWORD_ADD_OVF_EN adds the signed-overflow
// output ovf.

// 16-bit ripple-carry adder built from a chain of full adders.
module adder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [16:0] w_c;

    assign w_c[0] = cin;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_c[16];
endmodule

module multiword_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   in1,
    input  logic [16*WORDS-1:0]   in2,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   sum,
    output logic                  cout
`ifdef MULTIWORD_ADD_OVF_EN
    ,
    output logic                  ovf
`endif
);
    localparam int N  = 16 * WORDS;
    localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_sum;
    logic            r_carry;
    logic            r_cout;
    logic [KW-1:0]   r_k;

    logic [15:0]     w_a_slice;
    logic [15:0]     w_b_slice;
    logic [15:0]     w_add_sum;
    logic            w_add_cout;
    logic            w_accept;
    logic            w_last;

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == RUN) && (r_k == K_LAST);

    // Select the operand slice addressed by the slice index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_k == KW'(i)) begin
                w_a_slice = r_a[16*i +: 16];
                w_b_slice = r_b[16*i +: 16];
            end
        end
    end

    adder_16 u_adder (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, walk slices in RUN, hold in DONE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Operand capture on accept; one slice of the sum written per RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_a     <= in1;
            r_b     <= in2;
            r_carry <= cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_k     <= '0;
        end else if (r_state == RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (r_k == KW'(i)) begin
                    r_sum[16*i +: 16] <= w_add_sum;
                end
            end
            r_carry <= w_add_cout;
            r_k     <= r_k + 1'b1;
            if (w_last) begin
                r_cout <= w_add_cout;
            end
        end
    end

`ifdef MULTIWORD_ADD_OVF_EN
    logic r_ovf;

    // Two's-complement overflow, decided when the top slice is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a[N-1] == r_b[N-1]) && (w_add_sum[15] != r_a[N-1]);
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
endmodule
